// File: rtl/game_move_ctrl.sv
// Box-pushing game move controller: walks the man one cell per step_tick toward a
// latched target cell. A shared combinational single-step mover computes each move.

module game_man_move (
  input  logic [133:0] game_state,
  input  logic [5:0]   target,
  output logic [133:0] game_state_next,
  output logic         result
);

  localparam int unsigned GRID_N = 64;
  localparam int unsigned CELL_W = 6;
  localparam int unsigned AXIS_W = 3;

  logic [GRID_N-1:0] way;
  logic [GRID_N-1:0] box;
  logic [CELL_W-1:0] man;
  logic [GRID_N-1:0] way_n;
  logic [GRID_N-1:0] box_n;
  logic [CELL_W-1:0] man_n;
  logic              move_x;
  logic              move_y;
  logic              fwd;
  logic [AXIS_W-1:0] coord;
  logic [AXIS_W-1:0] c1_coord;
  logic [AXIS_W-1:0] c2_coord;
  logic              c2_ok;
  logic [CELL_W-1:0] c1;
  logic [CELL_W-1:0] c2;

  // Close the x distance first, then y; one cell per call.
  always_comb begin
    way      = game_state[133:70];
    box      = game_state[69:6];
    man      = game_state[5:0];
    way_n    = way;
    box_n    = box;
    man_n    = man;
    result   = 1'b0;
    move_x   = (man[2:0] != target[2:0]);
    move_y   = (man[5:3] != target[5:3]);
    fwd      = move_x ? (target[2:0] > man[2:0]) : (target[5:3] > man[5:3]);
    coord    = move_x ? man[2:0] : man[5:3];
    c1_coord = fwd ? coord + 3'd1 : coord - 3'd1;
    c2_coord = fwd ? coord + 3'd2 : coord - 3'd2;
    // The cell beyond the neighbour may fall off the 8x8 board.
    c2_ok    = fwd ? (coord <= 3'd5) : (coord >= 3'd2);
    c1       = move_x ? {man[5:3], c1_coord} : {c1_coord, man[2:0]};
    c2       = move_x ? {man[5:3], c2_coord} : {c2_coord, man[2:0]};

    if (move_x || move_y) begin
      if (box[c1]) begin
        if (c2_ok && way[c2] && !box[c2]) begin
          box_n[c1] = 1'b0;
          box_n[c2] = 1'b1;
          way_n[c1] = 1'b1;
          way_n[c2] = 1'b0;
          man_n     = c1;
          result    = 1'b1;
        end
      end else if (way[c1]) begin
        man_n  = c1;
        result = 1'b1;
      end
    end

    game_state_next = {way_n, box_n, man_n};
  end

endmodule

module game_move_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [133:0]     state_in,
  input  logic             go,
  input  logic [5:0]       cursor,
  input  logic             step_tick,
  output logic [133:0]     game_state,
  output logic             busy,
  output logic             done,
  output logic             blocked,
  output logic [CNT_W-1:0] steps,
  output logic [CNT_W-1:0] pushes
);

  localparam int unsigned STATE_W = 134;
  localparam int unsigned CELL_W  = 6;
  localparam logic [0:0]  IDLE    = 1'b0;
  localparam logic [0:0]  WALK    = 1'b1;

  logic [0:0]         state_q;
  logic [0:0]         state_d;
  logic [CELL_W-1:0]  target_q;
  logic [CELL_W-1:0]  target_d;
  logic [STATE_W-1:0] board_d;
  logic [CNT_W-1:0]   steps_d;
  logic [CNT_W-1:0]   pushes_d;
  logic [CNT_W-1:0]   steps_inc;
  logic [CNT_W-1:0]   pushes_inc;
  logic               done_d;
  logic               blocked_d;
  logic [STATE_W-1:0] mv_next;
  logic               mv_ok;
  logic               mv_pushed;

  game_man_move u_move (
    .game_state      (game_state),
    .target          (target_q),
    .game_state_next (mv_next),
    .result          (mv_ok)
  );

  assign busy = (state_q == WALK);

  // Saturating increments and push detection.
  always_comb begin
    steps_inc  = (steps == {CNT_W{1'b1}})  ? steps  : steps  + CNT_W'(1);
    pushes_inc = (pushes == {CNT_W{1'b1}}) ? pushes : pushes + CNT_W'(1);
    mv_pushed  = (mv_next[69:6] != game_state[69:6]);
  end

  // Next-state and next-output logic; load overrides everything.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    board_d   = game_state;
    steps_d   = steps;
    pushes_d  = pushes;
    done_d    = 1'b0;
    blocked_d = 1'b0;

    if (load) begin
      state_d  = IDLE;
      board_d  = state_in;
      steps_d  = '0;
      pushes_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            target_d = cursor;
            if (cursor == game_state[5:0]) begin
              done_d = 1'b1;
            end else begin
              state_d = WALK;
            end
          end
        end
        WALK: begin
          if (step_tick) begin
            if (mv_ok) begin
              board_d = mv_next;
              steps_d = steps_inc;
              if (mv_pushed) begin
                pushes_d = pushes_inc;
              end
              if (mv_next[5:0] == target_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              blocked_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      game_state <= '0;
      steps      <= '0;
      pushes     <= '0;
      done       <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      game_state <= board_d;
      steps      <= steps_d;
      pushes     <= pushes_d;
      done       <= done_d;
      blocked    <= blocked_d;
    end
  end

endmodule

// File: tb/tb_game_move_ctrl.sv
// Bench for game_move_ctrl: directed scenarios plus random walks checked against an
// array-based board model; a CNT_W=2 copy shares the stimulus to exercise saturation.

module tb_game_move_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [133:0] state_in;
  logic         go;
  logic [5:0]   cursor;
  logic         step_tick;

  logic [133:0] game_state;
  logic         busy, done, blocked;
  logic [15:0]  steps, pushes;
  logic [133:0] s_state;
  logic         s_busy, s_done, s_blocked;
  logic [1:0]   s_steps, s_pushes;

  game_move_ctrl dut (
    .clk(clk), .rst(rst), .load(load), .state_in(state_in), .go(go), .cursor(cursor),
    .step_tick(step_tick), .game_state(game_state), .busy(busy), .done(done),
    .blocked(blocked), .steps(steps), .pushes(pushes)
  );

  game_move_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .load(load), .state_in(state_in), .go(go), .cursor(cursor),
    .step_tick(step_tick), .game_state(s_state), .busy(s_busy), .done(s_done),
    .blocked(s_blocked), .steps(s_steps), .pushes(s_pushes)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Board model: plain arrays and integer coordinates.
  bit m_way [64];
  bit m_box [64];
  int m_man, m_target, m_steps, m_pushes;
  bit m_walk, m_done, m_blocked;

  function automatic logic [133:0] mk(input logic [63:0] w, input logic [63:0] b, input int m);
    return {w, b, 6'(m)};
  endfunction

  function automatic logic [133:0] m_pack();
    logic [63:0] w, b;
    for (int i = 0; i < 64; i++) begin
      w[i] = m_way[i];
      b[i] = m_box[i];
    end
    return {w, b, 6'(m_man)};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 64; i++) begin
      m_way[i] = 1'b0;
      m_box[i] = 1'b0;
    end
    m_man = 0; m_target = 0; m_steps = 0; m_pushes = 0;
    m_walk = 1'b0; m_done = 1'b0; m_blocked = 1'b0;
  endtask

  task automatic m_load(input logic [133:0] s);
    for (int i = 0; i < 64; i++) begin
      m_way[i] = s[70+i];
      m_box[i] = s[6+i];
    end
    m_man = int'(s[5:0]);
  endtask

  task automatic m_move(output bit ok, output bit pushed);
    int x, y, tx, ty, dx, dy, x1, y1, x2, y2, c1, c2;
    ok = 1'b0; pushed = 1'b0;
    x = m_man % 8; y = m_man / 8; tx = m_target % 8; ty = m_target / 8;
    dx = 0; dy = 0;
    if (x != tx) dx = (tx > x) ? 1 : -1;
    else if (y != ty) dy = (ty > y) ? 1 : -1;
    else return;
    x1 = x + dx; y1 = y + dy; x2 = x1 + dx; y2 = y1 + dy;
    c1 = y1 * 8 + x1;
    if (m_box[c1]) begin
      if (x2 >= 0 && x2 < 8 && y2 >= 0 && y2 < 8) begin
        c2 = y2 * 8 + x2;
        if (m_way[c2] && !m_box[c2]) begin
          m_box[c1] = 1'b0; m_box[c2] = 1'b1;
          m_way[c1] = 1'b1; m_way[c2] = 1'b0;
          m_man = c1; ok = 1'b1; pushed = 1'b1;
        end
      end
    end else if (m_way[c1]) begin
      m_man = c1; ok = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},   game_state, m_pack());
    chk({tag, ".busy"},    134'(busy), 134'(m_walk));
    chk({tag, ".done"},    134'(done), 134'(m_done));
    chk({tag, ".blocked"}, 134'(blocked), 134'(m_blocked));
    chk({tag, ".steps"},   134'(steps), 134'(sat(m_steps, 65535)));
    chk({tag, ".pushes"},  134'(pushes), 134'(sat(m_pushes, 65535)));
    chk({tag, ".s_state"}, s_state, m_pack());
    chk({tag, ".s_done"},  134'({s_busy, s_done, s_blocked}), 134'({m_walk, m_done, m_blocked}));
    chk({tag, ".s_steps"}, 134'(s_steps), 134'(sat(m_steps, 3)));
    chk({tag, ".s_push"},  134'(s_pushes), 134'(sat(m_pushes, 3)));
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after it.
  task automatic cycle(input bit ld, input logic [133:0] s, input bit g, input int c,
                       input bit st, input string tag);
    bit ok, p;
    load = ld; state_in = s; go = g; cursor = 6'(c); step_tick = st;
    @(posedge clk);
    m_done = 1'b0; m_blocked = 1'b0;
    if (ld) begin
      m_load(s); m_steps = 0; m_pushes = 0; m_walk = 1'b0;
    end else if (!m_walk) begin
      if (g) begin
        m_target = c;
        if (c == m_man) m_done = 1'b1;
        else m_walk = 1'b1;
      end
    end else if (st) begin
      m_move(ok, p);
      if (ok) begin
        m_steps++;
        m_pushes += int'(p);
        if (m_man == m_target) begin
          m_done = 1'b1; m_walk = 1'b0;
        end
      end else begin
        m_blocked = 1'b1; m_walk = 1'b0;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, '0, 1'b0, 0, 1'b0, tag);
  endtask

  // Mid-cycle asynchronous reset, checked before the next clock edge.
  task automatic do_rst(input string tag);
    #2 rst = 1'b1;
    #1 m_clear();
    check_all(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [133:0] snap_free, snap_push, snap_wall, snap_sat, snap_rnd;
  logic [63:0]  rw, rb;

  initial begin
    rst = 1'b1; load = 1'b0; state_in = '0; go = 1'b0; cursor = '0; step_tick = 1'b0;
    m_clear();
    #3 check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    snap_free = mk((64'(1) << 10) | (64'(1) << 11) | (64'(1) << 12), 64'd0, 9);
    snap_push = mk(64'(1) << 11, 64'(1) << 10, 9);
    snap_wall = mk(64'd0, 64'd0, 9);
    snap_sat  = mk((64'(1) << 10) | (64'(1) << 11) | (64'(1) << 12) | (64'(1) << 13) |
                   (64'(1) << 14), 64'd0, 9);

    // Free walk along a corridor, strobes spaced out.
    cycle(1'b1, snap_free, 1'b0, 0, 1'b0, "free.load");
    cycle(1'b0, '0, 1'b1, 12, 1'b0, "free.go");
    idle("free.hold");
    cycle(1'b0, '0, 1'b0, 0, 1'b1, "free.t1");
    idle("free.hold2");
    cycle(1'b0, '0, 1'b0, 0, 1'b1, "free.t2");
    cycle(1'b0, '0, 1'b0, 0, 1'b1, "free.t3");
    chk("free.man", 134'(game_state[5:0]), 134'(12));
    chk("free.stepcnt", 134'(steps), 134'(3));
    chk("free.donepulse", 134'({done, busy}), 134'(2'b10));
    idle("free.after");

    // Push one box, then blocked by a box against a wall.
    cycle(1'b1, snap_push, 1'b0, 0, 1'b0, "push.load");
    cycle(1'b0, '0, 1'b1, 11, 1'b1, "push.go_tick");
    cycle(1'b0, '0, 1'b0, 0, 1'b1, "push.t1");
    chk("push.board", game_state,
        mk((64'(1) << 10), (64'(1) << 11), 10));
    chk("push.cnt", 134'(pushes), 134'(1));
    cycle(1'b0, '0, 1'b1, 40, 1'b1, "push.t2");
    chk("push.blocked", 134'(blocked), 134'(1));

    // Wall directly ahead.
    cycle(1'b1, snap_wall, 1'b0, 0, 1'b0, "wall.load");
    cycle(1'b0, '0, 1'b1, 10, 1'b0, "wall.go");
    cycle(1'b0, '0, 1'b0, 0, 1'b1, "wall.t1");
    chk("wall.board", game_state, snap_wall);
    chk("wall.blocked", 134'({blocked, done}), 134'(2'b10));
    idle("wall.after");

    // Target already under the man.
    cycle(1'b0, '0, 1'b1, 9, 1'b0, "triv.go");
    chk("triv.done", 134'({done, busy}), 134'(2'b10));
    idle("triv.after");

    // Load coincident with step_tick aborts a walk; then reset mid-walk.
    cycle(1'b1, snap_free, 1'b0, 0, 1'b0, "abort.load");
    cycle(1'b0, '0, 1'b1, 12, 1'b0, "abort.go");
    cycle(1'b0, '0, 1'b0, 0, 1'b1, "abort.t1");
    cycle(1'b1, snap_push, 1'b0, 0, 1'b1, "abort.reload");
    chk("abort.snap", game_state, snap_push);
    idle("abort.idle");
    cycle(1'b1, snap_free, 1'b0, 0, 1'b0, "abort.load2");
    cycle(1'b0, '0, 1'b1, 12, 1'b0, "abort.go2");
    cycle(1'b0, '0, 1'b0, 0, 1'b1, "abort.t2");
    do_rst("abort.rst");
    idle("abort.post1");
    cycle(1'b0, '0, 1'b0, 0, 1'b1, "abort.post2");

    // Five legal steps: the narrow counter saturates, done still fires.
    cycle(1'b1, snap_sat, 1'b0, 0, 1'b0, "sat.load");
    cycle(1'b0, '0, 1'b1, 14, 1'b0, "sat.go");
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 0, 1'b1, "sat.tick");
    chk("sat.s_steps", 134'(s_steps), 134'(3));
    chk("sat.s_done", 134'(s_done), 134'(1));
    chk("sat.steps", 134'(steps), 134'(5));

    // Random boards and random go/step/load traffic.
    for (int r = 0; r < 25; r++) begin
      rw = {$urandom, $urandom} | {$urandom, $urandom};
      rb = {$urandom, $urandom} & {$urandom, $urandom} & ~rw;
      snap_rnd = mk(rw, rb, int'($urandom_range(0, 63)));
      snap_rnd[70 + int'(snap_rnd[5:0])] = 1'b1;
      snap_rnd[6 + int'(snap_rnd[5:0])]  = 1'b0;
      cycle(1'b1, snap_rnd, 1'b0, 0, 1'b0, "rnd.load");
      for (int k = 0; k < 40; k++) begin
        cycle(($urandom % 50) == 0, snap_rnd, ($urandom % 4) == 0,
              int'($urandom_range(0, 63)), ($urandom % 3) == 0, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
